// File: rtl/lane_scatter_tx.sv
// lane_scatter_tx: buffers whole input vectors in a small FIFO and scatters the
// head vector across NUM_LANES independently handshaken output lanes. A vector
// retires once every lane has completed its own handshake.
// Optional feature macro: LANE_SCATTER_TX_STATS_EN (adds saturating stats counters).

package cnn1d_pkg;
    localparam int unsigned DATA_WIDTH = 12;
endpackage

module lane_scatter_tx
    import cnn1d_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  tx_ready_in,
    input  logic                  tx_valid_in,
    input  logic [DATA_WIDTH-1:0] tx_data_in  [0:NUM_LANES-1],
    input  logic [NUM_LANES-1:0]  tx_ready_out,
    output logic [NUM_LANES-1:0]  tx_valid_out,
    output logic [DATA_WIDTH-1:0] tx_data_out [0:NUM_LANES-1]
`ifdef LANE_SCATTER_TX_STATS_EN
    ,
    output logic [15:0]           stat_vectors_sent,
    output logic [15:0]           stat_stall_cycles
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1][0:NUM_LANES-1];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic [NUM_LANES-1:0]  r_done;

    logic [PTR_W-1:0]      w_wptr_nxt;
    logic [PTR_W-1:0]      w_rptr_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [NUM_LANES-1:0]  w_done_nxt;

    logic                  w_not_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_retire;
    logic [NUM_LANES-1:0]  w_fire;

    // Handshake decode; everything here depends only on registered state and the
    // same-cycle lane readies, so tx_ready_in never sees tx_ready_out.
    assign w_not_empty  = (r_count != CNT_W'(0));
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign tx_ready_in  = !w_full;
    assign w_push       = tx_valid_in && !w_full;
    assign tx_valid_out = {NUM_LANES{w_not_empty}} & ~r_done;
    assign w_fire       = tx_valid_out & tx_ready_out;
    assign w_retire     = w_not_empty && (&(r_done | w_fire));

    // Head entry is always presented; lanes that already fired simply drop valid.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            tx_data_out[l] = r_mem[r_rptr][l];
        end
    end

    // Next-state for pointers, occupancy and per-lane done mask.
    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        w_done_nxt  = r_done | w_fire;
        if (w_push) begin
            w_wptr_nxt = r_wptr + PTR_W'(1);
        end
        if (w_retire) begin
            w_rptr_nxt = r_rptr + PTR_W'(1);
            w_done_nxt = '0;
        end
        case ({w_push, w_retire})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Control state registers; reset flushes every buffered and partial vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_done  <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Vector storage; contents are don't-care until written so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_mem[r_wptr][l] <= tx_data_in[l];
            end
        end
    end

`ifdef LANE_SCATTER_TX_STATS_EN
    logic [15:0] r_stat_sent;
    logic [15:0] r_stat_stall;

    // Saturating counters: retired vectors and occupied cycles with no lane progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_sent  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_retire && (r_stat_sent != 16'hFFFF)) begin
                r_stat_sent <= r_stat_sent + 16'd1;
            end
            if (w_not_empty && (w_fire == '0) && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_vectors_sent = r_stat_sent;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_lane_scatter_tx.sv
// Testbench for lane_scatter_tx: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_lane_scatter_tx;
    import cnn1d_pkg::*;

    localparam int unsigned NL = 2;
    localparam int unsigned DP = 4;

    typedef logic [NL-1:0][DATA_WIDTH-1:0] vec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  tx_ready_in;
    logic                  tx_valid_in;
    logic [DATA_WIDTH-1:0] tx_data_in  [0:NL-1];
    logic [NL-1:0]         tx_ready_out;
    logic [NL-1:0]         tx_valid_out;
    logic [DATA_WIDTH-1:0] tx_data_out [0:NL-1];
`ifdef LANE_SCATTER_TX_STATS_EN
    logic [15:0]           stat_vectors_sent;
    logic [15:0]           stat_stall_cycles;
`endif

    lane_scatter_tx #(.NUM_LANES(NL), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_ready_in  (tx_ready_in),
        .tx_valid_in  (tx_valid_in),
        .tx_data_in   (tx_data_in),
        .tx_ready_out (tx_ready_out),
        .tx_valid_out (tx_valid_out),
        .tx_data_out  (tx_data_out)
`ifdef LANE_SCATTER_TX_STATS_EN
        ,
        .stat_vectors_sent (stat_vectors_sent),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of pending vectors plus set of lanes already served.
    vec_t          q[$];
    logic [NL-1:0] sent;
    int            m_sent_cnt;
    int            m_stall_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t vec2(input logic [DATA_WIDTH-1:0] e0, input logic [DATA_WIDTH-1:0] e1);
        vec_t v;
        v[0] = e0;
        v[1] = e1;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int l = 0; l < NL; l++) v[l] = DATA_WIDTH'($urandom);
        return v;
    endfunction

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic step(input bit do_rst, input bit push, input logic [NL-1:0] rdy, input vec_t v);
        logic [NL-1:0] ev;
        logic [NL-1:0] fire;
        bit            accept;
        @(negedge clk);
        rst          = do_rst;
        tx_valid_in  = push;
        tx_ready_out = rdy;
        for (int l = 0; l < NL; l++) tx_data_in[l] = v[l];

        check_eq("ready_in", 32'(tx_ready_in), 32'(q.size() < DP));
        for (int l = 0; l < NL; l++) ev[l] = (q.size() != 0) && !sent[l];
        check_eq("valid_out", 32'(tx_valid_out), 32'(ev));
        for (int l = 0; l < NL; l++) begin
            if (ev[l]) check_eq($sformatf("data_out[%0d]", l), 32'(tx_data_out[l]), 32'(q[0][l]));
        end
`ifdef LANE_SCATTER_TX_STATS_EN
        check_eq("stat_sent", 32'(stat_vectors_sent), 32'(m_sent_cnt));
        check_eq("stat_stall", 32'(stat_stall_cycles), 32'(m_stall_cnt));
`endif

        if (do_rst) begin
            q.delete();
            sent        = '0;
            m_sent_cnt  = 0;
            m_stall_cnt = 0;
        end else begin
            fire   = ev & rdy;
            accept = push && (q.size() < DP);
            if (q.size() != 0 && fire == '0 && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
            if (q.size() != 0 && ((sent | fire) == {NL{1'b1}})) begin
                void'(q.pop_front());
                sent = '0;
                if (m_sent_cnt < 16'hFFFF) m_sent_cnt++;
            end else begin
                sent = sent | fire;
            end
            if (accept) q.push_back(v);
        end
    endtask

    initial begin
        rst          = 1'b1;
        tx_valid_in  = 1'b0;
        tx_ready_out = '0;
        for (int l = 0; l < NL; l++) tx_data_in[l] = '0;
        sent        = '0;
        m_sent_cnt  = 0;
        m_stall_cnt = 0;
        repeat (2) @(posedge clk);

        // Single vector, both lanes ready
        step(0, 1, 2'b11, vec2(12'h200, 12'h000));
        step(0, 0, 2'b11, '0);
        step(0, 0, 2'b11, '0);

        // Skewed lanes: lane 1 held off three cycles
        step(0, 1, 2'b01, vec2(12'h200, 12'h200));
        step(0, 0, 2'b01, '0);
        step(0, 0, 2'b01, '0);
        step(0, 0, 2'b01, '0);
        step(0, 0, 2'b11, '0);
        step(0, 0, 2'b11, '0);

        // Fill to full with lanes stalled, then drain
        for (int i = 0; i < 5; i++) step(0, 1, 2'b00, rand_vec());
        for (int i = 0; i < 6; i++) step(0, 0, 2'b11, '0);

        // Streaming push/pop, wraps pointers past DEPTH
        for (int i = 0; i < 10; i++) step(0, 1, 2'b11, rand_vec());
        for (int i = 0; i < 2; i++) step(0, 0, 2'b11, '0);

        // Reset with three buffered vectors and lane 0 already served
        for (int i = 0; i < 3; i++) step(0, 1, 2'b00, rand_vec());
        step(0, 0, 2'b01, '0);
        step(1, 0, 2'b00, '0);
        step(0, 1, 2'b11, rand_vec());
        step(0, 0, 2'b00, '0);
        step(0, 0, 2'b11, '0);

        // Randomized traffic with varying push and ready densities
        for (int i = 0; i < 800; i++) begin
            int unsigned mode = (i / 100) % 4;
            bit push;
            logic [NL-1:0] rdy;
            push = ($urandom_range(0, 3) < ((mode == 1) ? 1 : 3));
            for (int l = 0; l < NL; l++) rdy[l] = ($urandom_range(0, 3) < ((mode == 2) ? 1 : 3));
            if (mode == 3) rdy = {NL{1'b1}};
            step(($urandom_range(0, 199) == 0), push, rdy, rand_vec());
        end

        for (int i = 0; i < 8; i++) step(0, 0, 2'b11, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lane_scatter_tx.md
# lane_scatter_tx

Transmit-side feeder for the multi-lane neuron input interface. It accepts whole input vectors from a single upstream valid/ready port, buffers them in a small FIFO, and presents the head vector on `NUM_LANES` independently handshaken output lanes, one lane per downstream neuron. A vector retires only after every lane has completed its own handshake. It is the producer that drives a network's per-lane `ready_in`/`valid_in`/`data_in` port.

## Interface

- `NUM_LANES`, 2, number of output lanes and data elements per vector (≥1).
- `DEPTH`, 4, FIFO depth in vectors; power of two, ≥2.
- `DATA_WIDTH`, from `cnn1d_pkg` (12), width of each data element. Package constant, not overridable.

- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tx_ready_in` output 1: upstream may push; equals FIFO not full.
- `tx_valid_in` input 1: upstream vector valid.
- `tx_data_in` input `DATA_WIDTH` × [0:`NUM_LANES`-1]: upstream vector.
- `tx_ready_out` input `NUM_LANES`: per-lane downstream ready.
- `tx_valid_out` output `NUM_LANES`: per-lane valid.
- `tx_data_out` output `DATA_WIDTH` × [0:`NUM_LANES`-1]: head vector; element `l` belongs to lane `l`.

## Operation

- Storage: `DEPTH`-entry vector array, write pointer, read pointer, count of width clog2(`DEPTH`)+1. Pointers wrap modulo `DEPTH`.
- Push: when `tx_valid_in && tx_ready_in`, write the vector at the write pointer and advance it.
- `tx_ready_in = (count != DEPTH)`. It is driven from the registered count only. It does not depend on a same-cycle pop, so there is no push at full.
- Per-lane done mask `done[NUM_LANES-1:0]`, registered.
- `tx_valid_out[l] = (count != 0) && !done[l]`.
- `tx_data_out` always shows the head entry. Its value is don't-care when the FIFO is empty.
- Lane fire: `fire[l] = tx_valid_out[l] && tx_ready_out[l]`.
- Retire condition: `(count != 0) && &(done | fire)`. On retire, pop, advance the read pointer, and clear `done` to 0. Otherwise `done <= done | fire`.
- Head state, derived from count and `done`:
  - EMPTY (count = 0). Goes to ISSUE on push.
  - ISSUE (count > 0, done = 0). Goes to PARTIAL when some lanes fire but not all. On retire it goes to ISSUE if entries remain, otherwise to EMPTY.
  - PARTIAL (done ≠ 0). Stays until the remaining lanes fire, then retires as above.
- Simultaneous push and retire: count is unchanged and both pointers advance.
- Once a lane fires it drops valid and ignores its ready until the next vector is at the head. Lanes never re-send.
- A lane's data is stable while its valid is high.

## Timing

- Reset values: `tx_ready_in` = 1, `tx_valid_out` = 0 on all lanes, `done` = 0, pointers and count = 0. `tx_data_out` is don't-care. Stats counters (when compiled in) = 0.
- Reset mid-operation flushes all buffered and partially sent vectors. No lane valid is asserted in the cycle after reset.
- Latency: a vector pushed into an empty FIFO at edge N is valid on all lanes in cycle N+1.
- Throughput: one vector per cycle when all `tx_ready_out` are held high and upstream streams.
- A partial retire takes as many cycles as the slowest lane.
- There is no combinational path from `tx_ready_out` to `tx_ready_in`.

## Configuration

- `LANE_SCATTER_TX_STATS_EN`, when defined, adds two output ports:
  - `stat_vectors_sent` [15:0]: increments on each retire.
  - `stat_stall_cycles` [15:0]: increments on every cycle with count > 0 and no lane fire.
  - Both counters saturate at 16'hFFFF and clear on `rst`.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan

- Single vector, `NUM_LANES`=2: push {12'h200, 12'h000} with both readies high. Both valids rise the next cycle with the same data and drop after one cycle. `tx_ready_in` stays 1.
- Skewed lanes: push {12'h200, 12'h200}. Hold lane 1 ready low for 3 cycles. Lane 0 fires once and drops valid. Lane 1 fires in cycle 4, then retire occurs and `done` returns to 0.
- Full: hold all readies low and push 5 vectors. The first 4 are accepted and `tx_ready_in`=0 after the 4th. Raising all readies drains the 4 vectors in order, one per cycle.
- Streaming with simultaneous push and pop: continuous push with readies high for 10 cycles. 10 vectors are sent in order, count stays ≤1, and the read pointer wraps correctly past `DEPTH`.
- Reset mid-operation: 3 vectors buffered and lane 0 done. Assert `rst` for one cycle. All valids are 0 in the next cycle, `tx_ready_in`=1, and a new push appears with `done`=0.
- With `LANE_SCATTER_TX_STATS_EN`: the skewed-lane case yields `stat_vectors_sent`=1 and `stat_stall_cycles`=2.
